// File: rtl/instr_encoder_pkg.sv
// Shared constants and types for the instruction encoder: op classes, DP commands,
// the always-condition and the loader FSM states.
package instr_encoder_pkg;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_B   = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_AL = 4'hE;

    typedef enum logic {
        StLoad,
        StFull
    } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: decoded instruction fields to a 32-bit ARM word, plus a flag
// for bundles outside the implemented subset.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [1:0]  op_i,
    input  logic [3:0]  cond_i,
    input  logic [3:0]  cmd_i,
    input  logic        s_i,
    input  logic        i_i,
    input  logic        l_i,
    input  logic [3:0]  rn_i,
    input  logic [3:0]  rd_i,
    input  logic [3:0]  rm_i,
    input  logic [23:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    logic        cmd_ok;
    logic [11:0] dp_operand;

    always_comb begin
        cmd_ok = 1'b0;
        unique case (cmd_i)
            CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_MOV: cmd_ok = 1'b1;
            default:                                     cmd_ok = 1'b0;
        endcase
    end

    // Rotation and shift amounts are always zero in the supported subset.
    assign dp_operand = i_i ? {4'h0, imm_i[7:0]} : {8'h00, rm_i};

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (op_i)
            OP_DP: begin
                word_o    = {cond_i, 2'b00, i_i, cmd_i, s_i, rn_i, rd_i, dp_operand};
                illegal_o = ~cmd_ok | (i_i & (|imm_i[23:8]));
            end
            OP_MEM: begin
                word_o    = {cond_i, 7'b0101100, l_i, rn_i, rd_i, imm_i[11:0]};
                illegal_o = |imm_i[23:12];
            end
            OP_B: begin
                word_o    = {cond_i, 4'b1010, imm_i};
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Loader-side instruction encoder: packs field bundles into ARM words and streams them
// into imem through a single registered write slot with back-pressure.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [1:0]        in_op_i,
    input  logic [3:0]        in_cond_i,
    input  logic [3:0]        in_cmd_i,
    input  logic              in_s_i,
    input  logic              in_i_i,
    input  logic              in_l_i,
    input  logic [3:0]        in_rn_i,
    input  logic [3:0]        in_rd_i,
    input  logic [3:0]        in_rm_i,
    input  logic [23:0]       in_imm_i,
    output logic              imem_we_o,
    input  logic              imem_ready_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              full_o,
    output logic              err_o
);

    localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

    logic [31:0] word;
    logic        illegal;

    instr_pack u_pack (
        .op_i      (in_op_i),
        .cond_i    (in_cond_i),
        .cmd_i     (in_cmd_i),
        .s_i       (in_s_i),
        .i_i       (in_i_i),
        .l_i       (in_l_i),
        .rn_i      (in_rn_i),
        .rd_i      (in_rd_i),
        .rm_i      (in_rm_i),
        .imm_i     (in_imm_i),
        .word_o    (word),
        .illegal_o (illegal)
    );

    enc_state_e        state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   count_q;
    logic              err_q;

    logic              commit;
    logic              slot_free;
    logic              accept;
    logic [ADDR_W:0]   count_inc;

    assign commit    = we_q & imem_ready_i;
    assign count_inc = count_q + (ADDR_W + 1)'(1);
    // The pending write already owns an address; refuse a bundle that would land past DEPTH.
    assign slot_free = (count_q + {{ADDR_W{1'b0}}, we_q}) < DepthW;
    assign in_ready_o = (state_q == StLoad) & (~we_q | imem_ready_i) & slot_free;
    assign accept     = in_valid_i & in_ready_o & ~clr_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StLoad;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (clr_i) begin
            state_q <= StLoad;
            we_q    <= 1'b0;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (commit) begin
                addr_q  <= addr_q + ADDR_W'(1);
                count_q <= count_inc;
                if (count_inc == DepthW) begin
                    state_q <= StFull;
                end
            end
            if (accept && !illegal) begin
                we_q    <= 1'b1;
                wdata_q <= word;
            end else if (commit) begin
                we_q    <= 1'b0;
            end
            if (accept && illegal) begin
                err_q <= 1'b1;
            end
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign word_count_o = count_q;
    assign full_o       = (state_q == StFull);
    assign err_o        = err_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the control decoder: takes decoded instruction fields and packs them into 32-bit ARM machine words for the implemented subset (ADD/SUB/AND/ORR/MOV, LDR/STR immediate offset, B).
- Streams the encoded words into instruction memory through a registered write port with back-pressure.
- Used by the test/boot loader to fill imem before the core leaves reset.

Parameters:
- ADDR_W, 6, word-address width of imem.
- DEPTH, 64, number of words that may be written before FULL (DEPTH <= 2**ADDR_W).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low (0 = reset)
- clr  in  1  synchronous restart: address/count to 0, err cleared, state LOAD
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- in_op  in  2  00 DP, 01 MEM, 10 B, 11 illegal
- in_cond  in  4  condition field
- in_cmd  in  4  DP cmd: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1101 MOV
- in_s  in  1  DP S bit
- in_i  in  1  DP: 1 = imm8 operand, 0 = register Rm
- in_l  in  1  MEM: 1 = LDR, 0 = STR
- in_rn, in_rd, in_rm  in  4 each  register numbers
- in_imm  in  24  imm8 (DP), imm12 (MEM) or imm24 (B), right-aligned
- imem_we  out  1  write strobe (valid)
- imem_ready  in  1  memory accepts the write
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- word_count  out  ADDR_W+1  words committed
- full  out  1  DEPTH words committed
- err  out  1  sticky: a bundle was rejected

Behaviour:
- Reset: imem_we=0, imem_addr=0, imem_wdata=0, word_count=0, full=0, err=0, state LOAD.
- FSM states:
  - LOAD: in_ready = ~imem_we | imem_ready.
  - FULL: in_ready=0. Entered when word_count reaches DEPTH on a write commit.
  - Exit from FULL only by clr or reset.
- Accept = in_valid & in_ready.
- Legal bundle: the encoded word is registered onto imem_wdata, and imem_we=1 on the next cycle (latency 1).
- imem_we/addr/wdata hold stable until imem_ready=1 (commit). On commit, addr and word_count increment.
- Accept and commit in the same cycle is allowed: this gives full throughput of 1 word/cycle.
- Encoding, bits [31:28] = cond in all cases:
  - DP: [27:26]=00, [25]=I, [24:21]=cmd, [20]=S, [19:16]=Rn, [15:12]=Rd.
    - [11:0] = {4'h0, imm8} when I=1 (rot=0).
    - [11:0] = {8'h00, Rm} when I=0 (shift 0).
  - MEM: [27:20] = 0101_100L (immediate offset, P=1, U=1, B=0, W=0), [19:16]=Rn, [15:12]=Rd, [11:0]=imm12.
  - B: [27:24]=1010, [23:0]=imm24.
- Illegal bundle is accepted (consumes the handshake), produces no write, and sets err. Illegal means any of:
  - in_op=11;
  - DP with cmd outside the five listed;
  - DP I=1 with in_imm[23:8]!=0;
  - MEM with in_imm[23:12]!=0.
- Unused field inputs are ignored.
- clr while a write is pending drops the pending write (imem_we=0 next cycle). clr has priority over accept in the same cycle.
- Reset mid-write: imem_we deasserts immediately (asynchronous).
- imem_addr never wraps: FULL is entered before it can.

Decomposition:
- Shared package (extend the core package): op-class constants (OP_DP, OP_MEM, OP_B), cmd constants (CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_MOV), cond AL=4'hE, and an enum for the FSM states.
- One combinational sub-module, instr_pack: fields in, 32-bit word and illegal flag out.
- The top level holds the handshake register, counters and FSM.

Test Plan:
- After reset, send the following bundles with cond=E and imem_ready=1 tied high. Required: writes on consecutive cycles to addr 0..4 with these words, and word_count=5.
  - ADD R2,R3,#5 (I=1) -> E2832005
  - SUB R1,R2,R3 -> E0421003
  - LDR R1,[R0,#4] -> E5901004
  - STR R1,[R0,#8] -> E5801008
  - B imm24=2 -> EA000002
- MOV R0,#0xFF (cmd 1101, Rn=0) -> E3A000FF. ORR R4,R5,R6 S=1 -> E1954006.
- Hold imem_ready=0 for 3 cycles with in_valid=1. Required:
  - imem_we/addr/wdata are stable;
  - in_ready=0;
  - no bundle is lost, and on release the order is preserved.
- Illegal bundles, each giving no write, err=1 and word_count unchanged:
  - op=11;
  - cmd=0001;
  - MEM imm=0x1000.
  - The next legal bundle is then written at the unchanged addr.
- Write DEPTH words. Required: full=1 and in_ready=0. Then pulse clr: addr=0, full=0, err=0, in_ready=1.
- Two further cases:
  - Assert reset while imem_we=1: imem_we drops at once and all outputs take their reset values.
  - Assert clr in the same cycle as an accept: the bundle is dropped.
